parallel_mem_stream_ctrl: RTL and testbench
===========================================

# parallel_mem_stream_ctrl

Streaming controller that sits directly in front of and behind the parallel simple dual-port memory bank (z memories, `depth` cells, `width` bits). It accepts z-lane beats on a valid/ready input and drives the bank's write port A. It issues reads on port B and presents the read data on a valid/ready output, so the bank behaves as a z-lane FIFO. It owns all pointer, occupancy, backpressure and read-latency bookkeeping for the bank.

## Interface
- `z`, 2, number of memories (lanes) in the collection
- `depth`, 16, cells per memory; any value ≥ 2, not restricted to powers of two
- `width`, 12, bits per cell
- `addrsize` (localparam), `(depth==1) ? 1 : $clog2(depth)`
- `cntsize` (localparam), `$clog2(depth+1)`
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `clear`  in  1  synchronous flush; same effect as reset but applied at the clock edge
- `in_valid`  in  1  upstream beat valid
- `in_ready`  out  1  beat accepted at the edge when `in_valid && in_ready`
- `in_mask`  in  z  per-lane write enable for the beat
- `in_data`  in  width × [z]  beat data, one word per lane
- `out_valid`  out  1  `out_data` holds a valid beat
- `out_ready`  in  1  downstream takes the beat at the edge when `out_valid && out_ready`
- `out_data`  out  width × [z]  equals `data_outB`, passed through combinationally
- `count`  out  cntsize  beats written and not yet popped
- `full`, `empty`  out  1  `count==depth` and `count==0` respectively
- `addressA`  out  addrsize × [z]  to the bank
- `weA`  out  z  to the bank
- `data_inA`  out  width × [z]  to the bank
- `addressB`  out  addrsize × [z]  to the bank
- `data_outB`  in  width × [z]  from the bank; valid one cycle after `addressB` is sampled

## Operation
- State:
  - `wr_ptr`, `rd_ptr` (addrsize)
  - `last_rd` (addrsize)
  - `count` (cntsize)
  - `pending` (cntsize): written but not yet issued for read
  - `out_valid` flag
- Derived signals:
  - `push = in_valid && in_ready`
  - `in_ready = !full`, forced to 0 while `reset` is asserted
  - `pop = out_valid && out_ready`
  - `issue = pending != 0 && (!out_valid || out_ready)`
- Write side:
  - All lanes: `addressA[i] = wr_ptr`, `data_inA[i] = in_data[i]`.
  - `weA = push ? in_mask : '0`.
  - On `push`, `wr_ptr` advances by one and wraps from depth-1 to 0.
  - A masked-off lane consumes its cell; its contents are unchanged.
- Read side:
  - All lanes: `addressB[i] = issue ? rd_ptr : last_rd`.
  - On `issue`: `last_rd <= rd_ptr`, and `rd_ptr` advances with the same wrap rule.
  - Holding `addressB` at `last_rd` keeps `data_outB` stable while the output is stalled.
- `out_valid` next state = `issue || (out_valid && !out_ready)`.
- Counters:
  - `count` next = `count + push - pop`.
  - `pending` next = `pending + push - issue`.
- Collision-free by construction:
  - A cell is read only after its write edge (`pending` counts committed writes only).
  - A cell is never rewritten while it is unpopped (`full` blocks writes).
  - The bank's read-first behaviour is therefore never exercised.
- Simultaneous push and pop when full: push is refused because `in_ready=0` at full. Throughput is one beat per cycle when neither full nor empty.
- Reset or `clear`:
  - `wr_ptr`, `rd_ptr`, `last_rd`, `count`, `pending` ← 0; `out_valid` ← 0.
  - Outputs: `empty`=1, `full`=0, `weA`=0, `addressA`=`addressB`=0.
  - In-flight beats are discarded; memory contents are not cleared.
  - `clear` has priority over `push`, `pop` and `issue` in the same cycle.

## Timing
- Latency from a push at edge n to `out_valid` high: issue in cycle n+1, `out_valid` high after edge n+1. Two edges minimum when the controller was empty.
- Sustained streaming: one beat in and one beat out per cycle, with no bubbles while `pending > 0` and `out_ready` stays high.
- Backpressure:
  - `out_valid`, `out_data` and `addressB` are held constant while `out_valid && !out_ready`.
  - `out_valid` never drops without a pop.
- `count` and `full` are registered-derived. `in_ready` reflects the current `count` only; a same-cycle pop does not free a slot for that cycle's push.

## Structure
- Shared package `psdp_pkg` holds:
  - the `addrsize` and `cntsize` width functions;
  - typedefs for lane arrays.
- One sub-module, `wrap_counter #(depth)` (increment enable, synchronous clear, async active-low reset, wraps at depth-1), instantiated twice for `wr_ptr` and `rd_ptr`.
- The memory bank is instantiated by the parent, not inside this block.

## Test plan
All scenarios use z=2, depth=16, width=12, with a behavioural bank model of 1-cycle read latency.
- Single beat: push {0x005, 0x006} with mask 2'b11; `out_ready`=1 → `weA`=2'b11 at cell 0; `out_valid` rises 2 edges after the push; `out_data`={0x005, 0x006}; `count` goes 1 then 0.
- Fill to full: 16 consecutive pushes with `out_ready`=0 → `full`=1, `in_ready`=0, `count`=16. The 17th beat is not written (`weA`=0).
- Stall hold: 3 beats queued; `out_ready` low for 5 cycles → `out_data`, `addressB` and `out_valid` are constant. Releasing `out_ready` yields the beats in order with no gaps.
- Wrap: 20 pushes interleaved with pops → `wr_ptr` and `rd_ptr` wrap from 15 to 0; output order matches input order for data 0x001..0x014.
- Mask: push {0x063, 0x064} with mask 2'b10 into a previously written cell → lane 1 reads 0x064; lane 0 keeps its old value.
- `clear` with 4 beats queued and `out_valid`=1 → next cycle `count`=0, `empty`=1, `out_valid`=0. A subsequent push reads back correctly from cell 0.
- Async reset asserted mid-cycle → `out_valid`=0 and `in_ready`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/parallel_mem_stream_ctrl_pkg.sv
// Shared widths and lane typedefs for the parallel simple dual-port memory bank
// and its stream controller.
package psdp_pkg;

  function automatic int addrSize(input int d);
    return (d == 1) ? 1 : $clog2(d);
  endfunction

  function automatic int cntSize(input int d);
    return $clog2(d + 1);
  endfunction

  localparam int DefZ     = 2;
  localparam int DefDepth = 16;
  localparam int DefWidth = 12;

  typedef logic [DefWidth-1:0]     wordT;
  typedef wordT [DefZ-1:0]         laneWordsT;
  typedef logic [DefZ-1:0]         laneMaskT;

endpackage

// File: rtl/parallel_mem_stream_ctrl_wrap_counter.sv
// Modulo-depth pointer: advances on inc, wraps from depth-1 to 0, with
// synchronous clear and asynchronous active-low reset.
module wrap_counter import psdp_pkg::*; #(
  parameter int depth = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        inc,
  output logic [addrSize(depth)-1:0]  value
);

  localparam int aw = addrSize(depth);
  localparam logic [aw-1:0] lastVal = aw'(depth - 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == lastVal) ? '0 : value + aw'(1);
    end
  end

endmodule

// File: rtl/parallel_mem_stream_ctrl.sv
// Makes a z-lane simple dual-port memory bank behave as a valid/ready FIFO:
// pointers, occupancy, backpressure and one-cycle read latency live here.
module parallel_mem_stream_ctrl import psdp_pkg::*; #(
  parameter  int z        = 2,
  parameter  int depth    = 16,
  parameter  int width    = 12,
  localparam int addrsize = addrSize(depth),
  localparam int cntsize  = cntSize(depth)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [z-1:0]            in_mask,
  input  logic [z*width-1:0]      in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [z*width-1:0]      out_data,
  output logic [cntsize-1:0]      count,
  output logic                    full,
  output logic                    empty,
  output logic [z*addrsize-1:0]   addressA,
  output logic [z-1:0]            weA,
  output logic [z*width-1:0]      data_inA,
  output logic [z*addrsize-1:0]   addressB,
  input  logic [z*width-1:0]      data_outB
);

  localparam logic [cntsize-1:0] depthCnt = cntsize'(depth);

  logic [addrsize-1:0] wrPtr;
  logic [addrsize-1:0] rdPtr;
  logic [addrsize-1:0] lastRd;
  logic [cntsize-1:0]  pending;
  logic                push;
  logic                pop;
  logic                issue;

  assign full     = (count == depthCnt);
  assign empty    = (count == '0);
  // Gated by reset so upstream sees backpressure the instant reset asserts.
  assign in_ready = reset && !full;

  assign push  = in_valid && in_ready;
  assign pop   = out_valid && out_ready;
  assign issue = (pending != '0) && (!out_valid || out_ready);

  assign weA      = push ? in_mask : '0;
  assign data_inA = in_data;
  assign addressA = {z{wrPtr}};

  // Re-presenting the last issued address keeps data_outB stable during a stall.
  assign addressB = {z{issue ? rdPtr : lastRd}};
  assign out_data = data_outB;

  wrap_counter #(.depth(depth)) uWrPtr (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clear),
    .inc   (push),
    .value (wrPtr)
  );

  wrap_counter #(.depth(depth)) uRdPtr (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clear),
    .inc   (issue),
    .value (rdPtr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      pending   <= '0;
      lastRd    <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      count     <= '0;
      pending   <= '0;
      lastRd    <= '0;
      out_valid <= 1'b0;
    end else begin
      count     <= count + cntsize'(push) - cntsize'(pop);
      pending   <= pending + cntsize'(push) - cntsize'(issue);
      out_valid <= issue || (out_valid && !out_ready);
      if (issue) begin
        lastRd <= rdPtr;
      end
    end
  end

endmodule

// File: tb/tb_parallel_mem_stream_ctrl.sv
// Bench for parallel_mem_stream_ctrl with a 1-cycle-latency bank model and a
// queue-based FIFO reference.
module tb_parallel_mem_stream_ctrl;
  import psdp_pkg::*;

  localparam int Z     = DefZ;
  localparam int Depth = DefDepth;
  localparam int Width = DefWidth;
  localparam int Aw    = addrSize(Depth);
  localparam int Cw    = cntSize(Depth);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [Z-1:0]       in_mask = '0;
  logic [Z*Width-1:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [Z*Width-1:0] out_data;
  logic [Cw-1:0]      count;
  logic               full;
  logic               empty;
  logic [Z*Aw-1:0]    addressA;
  logic [Z-1:0]       weA;
  logic [Z*Width-1:0] data_inA;
  logic [Z*Aw-1:0]    addressB;
  logic [Z*Width-1:0] data_outB;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parallel_mem_stream_ctrl #(.z(Z), .depth(Depth), .width(Width)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .addressA  (addressA),
    .weA       (weA),
    .data_inA  (data_inA),
    .addressB  (addressB),
    .data_outB (data_outB)
  );

  // Behavioural bank: z independent memories, registered read on port B.
  logic [Width-1:0] bankMem [Z][Depth];
  always @(posedge clk) begin
    for (int i = 0; i < Z; i++) begin
      if (weA[i]) bankMem[i][addressA[i*Aw +: Aw]] <= data_inA[i*Width +: Width];
      data_outB[i*Width +: Width] <= bankMem[i][addressB[i*Aw +: Aw]];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic laneWordsT beat(input logic [11:0] w0, input logic [11:0] w1);
    laneWordsT b;
    b[0] = w0;
    b[1] = w1;
    return b;
  endfunction

  function automatic logic [2*Aw-1:0] addrPair(input int c);
    logic [Aw-1:0] a;
    a = Aw'(c);
    return {a, a};
  endfunction

  task automatic drive(input logic v, input logic [1:0] m, input logic [11:0] d0,
                       input logic [11:0] d1, input logic r);
    in_valid  = v;
    in_mask   = m;
    in_data   = beat(d0, d1);
    out_ready = r;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: FIFO of beats, cell contents tracked per lane so masked lanes
  // keep what the cell held before.
  laneWordsT        q[$];
  logic [Width-1:0] shadow [Z][Depth];
  int               wrCell = 0;
  bit               prevStall = 1'b0;

  always @(negedge clk) begin : monitor
    laneWordsT nb;
    bit        push;
    bit        pop;
    if (!reset) begin
      q.delete();
      wrCell    = 0;
      prevStall = 1'b0;
    end else begin
      check("mon_count", count, q.size());
      check("mon_in_ready", in_ready, q.size() < Depth);
      check("mon_full", full, q.size() == Depth);
      check("mon_empty", empty, q.size() == 0);
      if (prevStall) check("mon_hold_valid", out_valid, 1'b1);
      if (out_valid) begin
        if (q.size() == 0) check("mon_valid_when_empty", out_valid, 1'b0);
        else check("mon_out_data", out_data, q[0]);
      end
      pop  = out_valid && out_ready;
      push = in_valid && (q.size() < Depth);
      check("mon_weA", weA, push ? in_mask : 2'b00);
      nb = '0;
      if (push) begin
        check("mon_addrA", addressA, addrPair(wrCell));
        check("mon_data_inA", data_inA, in_data);
        for (int i = 0; i < Z; i++) begin
          if (in_mask[i]) shadow[i][wrCell] = in_data[i*Width +: Width];
          nb[i] = shadow[i][wrCell];
        end
      end
      if (clear) begin
        q.delete();
        wrCell = 0;
      end else begin
        if (pop && q.size() != 0) void'(q.pop_front());
        if (push) begin
          q.push_back(nb);
          wrCell = (wrCell + 1) % Depth;
        end
      end
      prevStall = out_valid && !out_ready && !clear;
    end
  end

  typedef struct {
    logic        v;
    logic [1:0]  m;
    logic [11:0] d0;
    logic [11:0] d1;
    logic        r;
    logic        expReady;
    logic [1:0]  expWe;
    logic [4:0]  expCount;
    logic        expValid;
    logic        chkData;
    laneWordsT   expData;
    int          expAddrA;
  } vecT;

  function automatic vecT mk(input logic v, input logic [1:0] m, input logic [11:0] d0,
                             input logic [11:0] d1, input logic r, input logic er,
                             input logic [1:0] ew, input int ec, input logic ev,
                             input logic cd, input laneWordsT ed, input int ea);
    vecT t;
    t.v = v; t.m = m; t.d0 = d0; t.d1 = d1; t.r = r;
    t.expReady = er; t.expWe = ew; t.expCount = 5'(ec); t.expValid = ev;
    t.chkData = cd; t.expData = ed; t.expAddrA = ea;
    return t;
  endfunction

  vecT vecs[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1);
  end

  initial begin : stim
    int  idx;
    bit  found;
    drive(0, 2'b00, 12'h0, 12'h0, 0);
    repeat (2) nextCycle();

    // Reset held: no acceptance, no writes, everything at zero.
    drive(1, 2'b11, 12'h0AA, 12'h0BB, 1);
    #2;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_weA", weA, 2'b00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_addrA", addressA, 0);
    check("rst_addrB", addressB, 0);
    drive(0, 2'b00, 12'h0, 12'h0, 0);
    reset = 1'b1;

    // Single beat, then fill to full with the output stalled.
    vecs.push_back(mk(1, 2'b11, 12'h005, 12'h006, 1, 1, 2'b11, 0, 0, 0, '0, 0));
    vecs.push_back(mk(0, 2'b00, 12'h000, 12'h000, 1, 1, 2'b00, 1, 0, 0, '0, 1));
    vecs.push_back(mk(0, 2'b00, 12'h000, 12'h000, 1, 1, 2'b00, 1, 1, 1, beat(12'h005, 12'h006), 1));
    vecs.push_back(mk(0, 2'b00, 12'h000, 12'h000, 1, 1, 2'b00, 0, 0, 0, '0, 1));
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(1, 2'b11, 12'h100 + 12'(k), 12'h200 + 12'(k), 0, 1, 2'b11, k,
                        k >= 2, k >= 2, beat(12'h100, 12'h200), (1 + k) % 16));
    vecs.push_back(mk(1, 2'b11, 12'h3FF, 12'h3FE, 0, 0, 2'b00, 16, 1, 1, beat(12'h100, 12'h200), 1));

    foreach (vecs[i]) begin
      nextCycle();
      drive(vecs[i].v, vecs[i].m, vecs[i].d0, vecs[i].d1, vecs[i].r);
      #2;
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].expReady);
      check($sformatf("vec%0d_weA", i), weA, vecs[i].expWe);
      check($sformatf("vec%0d_count", i), count, vecs[i].expCount);
      check($sformatf("vec%0d_full", i), full, vecs[i].expCount == 16);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].expValid);
      check($sformatf("vec%0d_addrA", i), addressA, addrPair(vecs[i].expAddrA));
      if (vecs[i].chkData) check($sformatf("vec%0d_out_data", i), out_data, vecs[i].expData);
    end

    // Drain the full FIFO: one beat per cycle in order.
    for (int j = 0; j < 16; j++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      check($sformatf("drain%0d_valid", j), out_valid, 1'b1);
      check($sformatf("drain%0d_data", j), out_data, beat(12'h100 + 12'(j), 12'h200 + 12'(j)));
      check($sformatf("drain%0d_count", j), count, 16 - j);
    end
    nextCycle();
    #2;
    check("drain_end_valid", out_valid, 1'b0);
    check("drain_end_empty", empty, 1'b1);

    // Stall hold: beat0 sits at cell 1, so addressB must stay on cell 1.
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      drive(1, 2'b11, 12'h300 + 12'(k), 12'h310 + 12'(k), 0);
    end
    for (int s = 0; s < 5; s++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 0);
      #2;
      check($sformatf("stall%0d_valid", s), out_valid, 1'b1);
      check($sformatf("stall%0d_data", s), out_data, beat(12'h300, 12'h310));
      check($sformatf("stall%0d_addrB", s), addressB, addrPair(1));
    end
    for (int j = 0; j < 3; j++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      check($sformatf("release%0d_valid", j), out_valid, 1'b1);
      check($sformatf("release%0d_data", j), out_data, beat(12'h300 + 12'(j), 12'h310 + 12'(j)));
    end
    nextCycle();
    #2;
    check("release_end_valid", out_valid, 1'b0);

    // Wrap: write pointer starts at cell 4, so 20 beats cross 15 -> 0.
    idx = 0;
    for (int c = 0; c < 40 && idx < 20; c++) begin
      nextCycle();
      if (c < 20) drive(1, 2'b11, 12'(c + 1), 12'h800 + 12'(c + 1), 1);
      else drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      if (c < 20) check($sformatf("wrap%0d_addrA", c), addressA, addrPair((4 + c) % 16));
      if (out_valid) begin
        check($sformatf("wrap_out%0d", idx), out_data, beat(12'(idx + 1), 12'h800 + 12'(idx + 1)));
        idx++;
      end
    end
    check("wrap_beats_seen", idx, 20);

    // Mask: cell 8 last held {0x005, 0x805}; only lane 1 is rewritten.
    nextCycle();
    drive(1, 2'b10, 12'h063, 12'h064, 1);
    #2;
    check("mask_weA", weA, 2'b10);
    check("mask_addrA", addressA, addrPair(8));
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      if (out_valid) begin
        found = 1'b1;
        check("mask_data", out_data, beat(12'h005, 12'h064));
      end
    end
    check("mask_seen", found, 1'b1);

    // Clear with four beats in flight.
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      drive(1, 2'b11, 12'h0A0 + 12'(k), 12'h0B0 + 12'(k), 0);
    end
    nextCycle();
    drive(0, 2'b00, 12'h0, 12'h0, 0);
    clear = 1'b1;
    #2;
    check("clr_pre_valid", out_valid, 1'b1);
    check("clr_pre_count", count, 4);
    nextCycle();
    clear = 1'b0;
    #2;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1'b1);
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);
    check("clr_addrA", addressA, addrPair(0));
    check("clr_addrB", addressB, addrPair(0));
    nextCycle();
    drive(1, 2'b11, 12'h0C1, 12'h0C2, 1);
    #2;
    check("clr_push_addrA", addressA, addrPair(0));
    check("clr_push_weA", weA, 2'b11);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      if (out_valid) begin
        found = 1'b1;
        check("clr_readback", out_data, beat(12'h0C1, 12'h0C2));
      end
    end
    check("clr_readback_seen", found, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 2; k++) begin
      nextCycle();
      drive(1, 2'b11, 12'h0D0 + 12'(k), 12'h0E0 + 12'(k), 0);
    end
    nextCycle();
    drive(0, 2'b00, 12'h0, 12'h0, 0);
    #2;
    check("arst_pre_valid", out_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b0);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1'b1);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    drive(1, 2'b11, 12'h0F1, 12'h0F2, 1);
    #2;
    check("arst_push_addrA", addressA, addrPair(0));
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      nextCycle();
      drive(0, 2'b00, 12'h0, 12'h0, 1);
      #2;
      if (out_valid) begin
        found = 1'b1;
        check("arst_readback", out_data, beat(12'h0F1, 12'h0F2));
      end
    end
    check("arst_readback_seen", found, 1'b1);

    // Random traffic against the reference, alternating drain-heavy and
    // fill-heavy stretches, with occasional clears.
    for (int c = 0; c < 600; c++) begin
      nextCycle();
      clear     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mask   = 2'($urandom);
      in_data   = 24'($urandom);
      out_ready = ((c % 200) < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    nextCycle();
    clear = 1'b0;
    drive(0, 2'b00, 12'h0, 12'h0, 1);
    for (int c = 0; c < 40; c++) begin
      nextCycle();
      #2;
      if (empty && !out_valid) break;
    end
    check("rand_drain_empty", empty, 1'b1);
    check("rand_drain_valid", out_valid, 1'b0);

    nextCycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
